// File: rtl/led_rgb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : led_rgb_ctrl                                                    |
// | Multi-channel RGB LED driver: off/steady/blink/counted-burst modes with  |
// | a shared blink prescaler. Define LED_RGB_PWM_EN for PWM dimming.         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module led_rgb_ctrl #(
   parameter int N_CH      = 1,
   parameter int BLINK_DIV = 25_000_000,
   parameter int PWM_W     = 4,
   parameter int BURST_W   = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic [N_CH-1:0]      load,
   input  logic [3*N_CH-1:0]    color,
   input  logic [2*N_CH-1:0]    mode,
   input  logic [PWM_W-1:0]     duty,
   input  logic [BURST_W-1:0]   burst_cnt,
   output logic [3*N_CH-1:0]    rgb_out,
   output logic [N_CH-1:0]      busy
);

   localparam logic [1:0] c_MODE_OFF    = 2'b00;
   localparam logic [1:0] c_MODE_STEADY = 2'b01;
   localparam logic [1:0] c_MODE_BLINK  = 2'b10;
   localparam logic [1:0] c_MODE_BURST  = 2'b11;

   localparam int                 c_DIV_W    = $clog2(BLINK_DIV);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BLINK_DIV - 1);

   logic [c_DIV_W-1:0] r_presc;
   logic               w_tick;

   assign w_tick = (r_presc == c_DIV_LAST);

   always_ff @(posedge clk_in) begin
      if (!rst_n)      r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + 1'b1;
   end

`ifdef LED_RGB_PWM_EN
   logic [PWM_W-1:0] r_pwm_cnt;

   always_ff @(posedge clk_in) begin
      if (!rst_n) r_pwm_cnt <= '0;
      else        r_pwm_cnt <= r_pwm_cnt + 1'b1;
   end
`else
   logic w_unused_duty;
   assign w_unused_duty = ^duty;
`endif

   wire [3*N_CH-1:0] w_rgb;
   wire [N_CH-1:0]   w_busy;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [2:0]         r_color;
      logic [1:0]         r_mode;
      logic [BURST_W-1:0] r_rem;
      logic               r_phase;
      logic [2:0]         r_rgb;
      logic               r_busy;
      logic [1:0]         w_mode_in;
      logic               w_gate;
      logic               w_pwm_on;

      assign w_mode_in = mode[2*i +: 2];

`ifdef LED_RGB_PWM_EN
      logic [PWM_W-1:0] r_duty;
      // Full-scale duty must be solid on, not (2^W-1)/2^W.
      assign w_pwm_on = (r_duty == '1) | (r_pwm_cnt < r_duty);
`else
      assign w_pwm_on = 1'b1;
`endif

      always_comb begin
         w_gate = 1'b0;
         case (r_mode)
            c_MODE_OFF:    w_gate = 1'b0;
            c_MODE_STEADY: w_gate = 1'b1;
            default:       w_gate = r_phase;
         endcase
      end

      always_ff @(posedge clk_in) begin
         if (!rst_n) begin
            r_color <= '0;
            r_mode  <= c_MODE_OFF;
            r_rem   <= '0;
            r_phase <= 1'b0;
            r_rgb   <= '0;
            r_busy  <= 1'b0;
`ifdef LED_RGB_PWM_EN
            r_duty  <= '0;
`endif
         end else begin
            if (load[i]) begin
               r_color <= color[3*i +: 3];
               r_rem   <= burst_cnt;
               r_phase <= 1'b1;
               // An empty burst never becomes busy.
               r_mode  <= ((w_mode_in == c_MODE_BURST) && (burst_cnt == '0)) ?
                          c_MODE_OFF : w_mode_in;
`ifdef LED_RGB_PWM_EN
               r_duty  <= duty;
`endif
            end else if (w_tick) begin
               case (r_mode)
                  c_MODE_BLINK: r_phase <= ~r_phase;
                  c_MODE_BURST: begin
                     if (r_phase) begin
                        r_phase <= 1'b0;
                        r_rem   <= r_rem - 1'b1;
                     end else if (r_rem == '0) begin
                        r_mode  <= c_MODE_OFF;
                     end else begin
                        r_phase <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            r_rgb  <= r_color & {3{w_gate & w_pwm_on}};
            r_busy <= (r_mode == c_MODE_BURST);
         end
      end

      assign w_rgb[3*i +: 3] = r_rgb;
      assign w_busy[i]       = r_busy;
   end

   assign rgb_out = w_rgb;
   assign busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_rgb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_led_rgb_ctrl                                                 |
// | Directed self-checking bench for led_rgb_ctrl (2 channels, div 4).       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_led_rgb_ctrl;

`ifdef LED_RGB_PWM_EN
   localparam bit c_PWM = 1'b1;
`else
   localparam bit c_PWM = 1'b0;
`endif

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic [1:0] load;
   logic [5:0] color;
   logic [3:0] mode;
   logic [1:0] duty;
   logic [2:0] burst_cnt;
   logic [5:0] rgb_out;
   logic [1:0] busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   led_rgb_ctrl #(
      .N_CH(2), .BLINK_DIV(4), .PWM_W(2), .BURST_W(3)
   ) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .load     (load),
      .color    (color),
      .mode     (mode),
      .duty     (duty),
      .burst_cnt(burst_cnt),
      .rgb_out  (rgb_out),
      .busy     (busy)
   );

   always #5 clk_in = ~clk_in;

   // cyc == j at the negedge following the j-th edge after reset release
   always @(posedge clk_in) cyc <= rst_n ? cyc + 1 : 0;

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_in);
   endtask

   initial begin
      logic on;
      logic b;
      rst_n = 1'b0; load = 2'b11; color = 6'b010_001; mode = 4'b01_01;
      duty = 2'd3; burst_cnt = 3'd0;

      // Reset holds everything dark even with load asserted
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_rgb", rgb_out, 6'b0);
         chk("rst_busy", {4'b0, busy}, 6'b0);
      end
      rst_n = 1'b1; load = 2'b00;
      step();
      chk("rel_rgb", rgb_out, 6'b0);
      chk("rel_busy", {4'b0, busy}, 6'b0);

      // ch0 steady red
      load = 2'b01; color = 6'b000_001; mode = 4'b00_01; duty = 2'd3;
      step();
      load = 2'b00;
      chk("steady_lat", rgb_out, 6'b0);
      for (int j = 3; j <= 6; j++) begin
         step();
         chk("steady", rgb_out, 6'b000_001);
      end

      // ch1 blink green, loaded at edge 7, ticks on edges 8,12,16,20
      load = 2'b10; color = 6'b010_000; mode = 4'b10_00; duty = 2'd3;
      step();
      load = 2'b00;
      chk("blink_lat", rgb_out, 6'b000_001);
      for (int j = 8; j <= 20; j++) begin
         step();
         on = (j == 8) || (j >= 13 && j <= 16);
         chk("blink", rgb_out, on ? 6'b010_001 : 6'b000_001);
      end

      // ch0 burst blue x2, loaded at edge 21
      load = 2'b01; color = 6'b000_100; mode = 4'b00_11; burst_cnt = 3'd2; duty = 2'd3;
      step();
      load = 2'b00;
      chk("burst_busy0", {5'b0, busy[0]}, 6'b0);
      for (int j = 22; j <= 38; j++) begin
         step();
         on = (j >= 22 && j <= 24) || (j >= 29 && j <= 32);
         b  = (j <= 36);
         chk("burst_rgb", {3'b0, rgb_out[2:0]}, on ? 6'b000_100 : 6'b0);
         chk("burst_busy", {5'b0, busy[0]}, {5'b0, b});
      end

      // ch0 white steady at duty 1: one cycle in four
      load = 2'b01; color = 6'b000_111; mode = 4'b00_01; duty = 2'd1;
      step();
      load = 2'b00;
      for (int j = 40; j <= 47; j++) begin
         step();
         on = !c_PWM || (j % 4 == 1);
         chk("pwm_d1", {3'b0, rgb_out[2:0]}, on ? 6'b000_111 : 6'b0);
      end

      // duty 0 is dark when dimming is built
      load = 2'b01; duty = 2'd0;
      step();
      load = 2'b00;
      for (int j = 49; j <= 51; j++) begin
         step();
         chk("pwm_d0", {3'b0, rgb_out[2:0]}, c_PWM ? 6'b0 : 6'b000_111);
      end

      // burst with count 0 goes straight to OFF
      load = 2'b01; color = 6'b000_100; mode = 4'b00_11; burst_cnt = 3'd0; duty = 2'd3;
      step();
      load = 2'b00;
      for (int j = 53; j <= 54; j++) begin
         step();
         chk("burst0_rgb", {3'b0, rgb_out[2:0]}, 6'b0);
         chk("burst0_busy", {5'b0, busy[0]}, 6'b0);
      end

      // Burst x2 at edge 55, then reload x3 on tick edge 60 (rem==1)
      load = 2'b01; color = 6'b000_001; mode = 4'b00_11; burst_cnt = 3'd2;
      step();
      load = 2'b00;
      for (int j = 56; j <= 59; j++) begin
         step();
         chk("pre_rgb", {3'b0, rgb_out[2:0]}, (j == 56) ? 6'b000_001 : 6'b0);
         chk("pre_busy", {5'b0, busy[0]}, 6'b000_001);
      end
      // ch1 runs the same burst with black colour: busy valid, output dark
      load = 2'b11; color = 6'b000_001; mode = 4'b11_11; burst_cnt = 3'd3;
      step();
      load = 2'b00;
      chk("tickload_busy", {5'b0, busy[0]}, 6'b000_001);
      for (int j = 61; j <= 86; j++) begin
         step();
         on = (j >= 61 && j <= 64) || (j >= 69 && j <= 72) || (j >= 77 && j <= 80);
         b  = (j <= 84);
         chk("reload_rgb", rgb_out, on ? 6'b000_001 : 6'b0);
         chk("reload_busy", {4'b0, busy}, {4'b0, b, b});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
